l2_maint_seq: RTL and testbench

- Maintenance sequencer between the merged instruction/data request bus and the L2 cache.
- Collects cache-invalidate requests from several requesters and serialises them.
- For each request it fences new accesses, drains outstanding reads, waits for the write-through buffer to empty, and then pulses the L2 invalidate.
- Acknowledges the served requesters, then reopens the bus.

---
 rtl/l2_maint_seq.sv | 162 ++++++++++++++++
 tb/tb_l2_maint_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_maint_seq.sv
`default_nettype none
// ============================================================================
// Module   : l2_maint_seq
// Brief    : Serialises L2 invalidate requests. Each round fences the merged
//            bus, drains outstanding reads, waits for the write-through buffer
//            to empty, pulses invalidate, settles, then acks the requesters.
// Revision : 1.0 - initial release
// ============================================================================
module l2_maint_seq #(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 32,
    parameter int OUTST_W     = 3,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic [N_REQ-1:0]      inv_req_i,
    output logic [N_REQ-1:0]      inv_ack_o,
    input  logic                  m_avalid_i,
    input  logic [DATA_W/8-1:0]   m_wstrb_i,
    output logic                  m_ready_o,
    output logic                  s_avalid_o,
    input  logic                  s_ready_i,
    input  logic                  s_rvalid_i,
    input  logic                  wtb_empty_i,
    output logic                  invalidate_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [OUTST_W-1:0] c_OUTST_MAX = {OUTST_W{1'b1}};
    localparam logic [c_SET_W-1:0] c_SET_LAST  = c_SET_W'(SETTLE_CYC - 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX    = c_TO_W'(TIMEOUT_CYC);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRAIN  = 3'd1;
    localparam logic [2:0] c_ST_WTB    = 3'd2;
    localparam logic [2:0] c_ST_INV    = 3'd3;
    localparam logic [2:0] c_ST_SETTLE = 3'd4;
    localparam logic [2:0] c_ST_ACK    = 3'd5;

    logic [2:0]         r_state,   w_state_nxt;
    logic [N_REQ-1:0]   r_snap,    w_snap_nxt;
    logic [c_SET_W-1:0] r_settle,  w_settle_nxt;
    logic [c_TO_W-1:0]  r_to_cnt,  w_to_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [OUTST_W-1:0] r_outst;

    logic w_idle;
    logic w_is_rd;
    logic w_rd_block;
    logic w_inc;
    logic w_dec;

    // Bus is only open in IDLE; a read is also held off when the counter is full.
    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_is_rd    = (m_wstrb_i == '0);
    assign w_rd_block = w_is_rd & (r_outst == c_OUTST_MAX);
    assign s_avalid_o = w_idle & m_avalid_i & ~w_rd_block;
    assign m_ready_o  = w_idle & s_ready_i & ~w_rd_block;

    assign w_inc = s_avalid_o & s_ready_i & w_is_rd;
    assign w_dec = s_rvalid_i & (r_outst != '0);

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            r_outst <= '0;
        end else if (cke_i) begin
            case ({w_inc, w_dec})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            r_state   <= c_ST_IDLE;
            r_snap    <= '0;
            r_settle  <= '0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (cke_i) begin
            r_state   <= w_state_nxt;
            r_snap    <= w_snap_nxt;
            r_settle  <= w_settle_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_snap_nxt    = r_snap;
        w_settle_nxt  = r_settle;
        w_to_cnt_nxt  = r_to_cnt;
        w_timeout_nxt = r_timeout;

        // Wait timer saturates; the flag is sticky and never aborts the round.
        if ((r_state == c_ST_DRAIN) || (r_state == c_ST_WTB)) begin
            if (r_to_cnt != c_TO_MAX) begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
            if (r_to_cnt == c_TO_LAST) begin
                w_timeout_nxt = 1'b1;
            end
        end

        case (r_state)
            c_ST_IDLE: begin
                w_to_cnt_nxt = '0;
                if (|inv_req_i) begin
                    w_snap_nxt  = inv_req_i;
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_outst == '0) begin
                    w_state_nxt = c_ST_WTB;
                end
            end
            c_ST_WTB: begin
                if (wtb_empty_i) begin
                    w_state_nxt = c_ST_INV;
                end
            end
            c_ST_INV: begin
                w_settle_nxt = '0;
                w_state_nxt  = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (r_settle == c_SET_LAST) begin
                    w_state_nxt = c_ST_ACK;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            c_ST_ACK: begin
                w_snap_nxt  = '0;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Pulses are masked while the clock enable is low and reappear once it returns.
    assign invalidate_o = cke_i & (r_state == c_ST_INV);
    assign inv_ack_o    = (cke_i && (r_state == c_ST_ACK)) ? r_snap : '0;
    assign busy_o       = ~w_idle;
    assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_l2_maint_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_maint_seq
// Brief    : Directed self-checking bench for l2_maint_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_maint_seq;

    logic       clk_i = 1'b0;
    logic       cke_i;
    logic       arst_i;
    logic [1:0] inv_req_i;
    logic [1:0] inv_ack_o;
    logic       m_avalid_i;
    logic [3:0] m_wstrb_i;
    logic       m_ready_o;
    logic       s_avalid_o;
    logic       s_ready_i;
    logic       s_rvalid_i;
    logic       wtb_empty_i;
    logic       invalidate_o;
    logic       busy_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    int inv_cnt  = 0;
    int ack_cnt  = 0;
    int i_base;
    int a_base;

    l2_maint_seq #(
        .N_REQ       (2),
        .DATA_W      (32),
        .OUTST_W     (2),
        .SETTLE_CYC  (2),
        .TIMEOUT_CYC (8)
    ) u_dut (
        .clk_i        (clk_i),
        .cke_i        (cke_i),
        .arst_i       (arst_i),
        .inv_req_i    (inv_req_i),
        .inv_ack_o    (inv_ack_o),
        .m_avalid_i   (m_avalid_i),
        .m_wstrb_i    (m_wstrb_i),
        .m_ready_o    (m_ready_o),
        .s_avalid_o   (s_avalid_o),
        .s_ready_i    (s_ready_i),
        .s_rvalid_i   (s_rvalid_i),
        .wtb_empty_i  (wtb_empty_i),
        .invalidate_o (invalidate_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (invalidate_o) inv_cnt <= inv_cnt + 1;
        if (inv_ack_o != 2'b00) ack_cnt <= ack_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cke_i       = 1'b1;
        arst_i      = 1'b1;
        inv_req_i   = 2'b00;
        m_avalid_i  = 1'b0;
        m_wstrb_i   = 4'h0;
        s_ready_i   = 1'b0;
        s_rvalid_i  = 1'b0;
        wtb_empty_i = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_ack", inv_ack_o, 0);
        chk("rst_inv", invalidate_o, 0);
        chk("rst_savalid", s_avalid_o, 0);
        chk("rst_mready", m_ready_o, 0);
        arst_i = 1'b0;
        tick();

        // Idle traffic, saturation at 3 reads, write still passes, no underflow.
        m_avalid_i = 1'b1;
        s_ready_i  = 1'b1;
        #1;
        chk("pt_savalid", s_avalid_o, 1);
        chk("pt_mready", m_ready_o, 1);
        repeat (3) tick();
        chk("sat_mready", m_ready_o, 0);
        chk("sat_savalid", s_avalid_o, 0);
        chk("sat_busy", busy_o, 0);
        m_wstrb_i = 4'hF;
        #1;
        chk("sat_wr_mready", m_ready_o, 1);
        chk("sat_wr_savalid", s_avalid_o, 1);
        tick();
        m_avalid_i = 1'b0;
        m_wstrb_i  = 4'h0;
        s_rvalid_i = 1'b1;
        repeat (4) tick();
        s_rvalid_i = 1'b0;
        m_avalid_i = 1'b1;
        #1;
        chk("drained_mready", m_ready_o, 1);
        repeat (2) tick();
        chk("uflow_mready2", m_ready_o, 1);
        tick();
        chk("uflow_mready3", m_ready_o, 0);
        m_avalid_i = 1'b0;
        s_rvalid_i = 1'b1;
        repeat (3) tick();
        s_rvalid_i = 1'b0;

        // Single request, write traffic on the bus throughout.
        m_avalid_i = 1'b1;
        m_wstrb_i  = 4'hF;
        inv_req_i  = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("sr_inv_c%0d", c), invalidate_o, (c == 3));
            chk($sformatf("sr_ack_c%0d", c), inv_ack_o, (c == 6) ? 2'b01 : 2'b00);
            chk($sformatf("sr_mready_c%0d", c), m_ready_o, (c >= 1 && c <= 6) ? 0 : 1);
            if (c == 6) inv_req_i = 2'b00;
        end

        // Drain two reads before invalidating.
        m_wstrb_i = 4'h0;
        repeat (2) tick();
        m_wstrb_i   = 4'hF;
        wtb_empty_i = 1'b0;
        inv_req_i   = 2'b10;
        i_base      = inv_cnt;
        for (int c = 1; c <= 10; c++) begin
            tick();
            s_rvalid_i = (c == 2 || c == 3);
            if (c == 3) wtb_empty_i = 1'b1;
            chk($sformatf("dr_inv_c%0d", c), invalidate_o, (c == 6));
            chk($sformatf("dr_ack_c%0d", c), inv_ack_o, (c == 9) ? 2'b10 : 2'b00);
            chk($sformatf("dr_busy_c%0d", c), busy_o, (c <= 9));
            if (c == 9) inv_req_i = 2'b00;
        end
        chk("dr_timeout", timeout_o, 0);
        chk("dr_inv_count", inv_cnt - i_base, 1);

        // Late request joins the next round, not the current one.
        inv_req_i = 2'b01;
        i_base    = inv_cnt;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 2) inv_req_i = 2'b11;
            chk($sformatf("lr_inv_c%0d", c), invalidate_o, (c == 3 || c == 10));
            chk($sformatf("lr_ack_c%0d", c), inv_ack_o,
                (c == 6) ? 2'b01 : ((c == 13) ? 2'b10 : 2'b00));
            chk($sformatf("lr_busy_c%0d", c), busy_o, !(c == 7 || c == 14));
            if (c == 6) inv_req_i = 2'b10;
            if (c == 13) inv_req_i = 2'b00;
        end
        chk("lr_inv_count", inv_cnt - i_base, 2);

        // Buffer never empties: sticky timeout, sequence keeps waiting.
        wtb_empty_i = 1'b0;
        inv_req_i   = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("to_inv_c%0d", c), invalidate_o, 0);
            if (c == 8) chk("to_before", timeout_o, 0);
            if (c == 10) chk("to_after", timeout_o, 1);
        end
        chk("to_busy", busy_o, 1);
        wtb_empty_i = 1'b1;
        tick();
        chk("to_inv", invalidate_o, 1);
        repeat (3) tick();
        chk("to_ack", inv_ack_o, 2'b01);
        inv_req_i = 2'b00;
        tick();
        chk("to_sticky", timeout_o, 1);
        chk("to_done_busy", busy_o, 0);

        // Reset while settling: no ack, fence drops, held request restarts.
        inv_req_i = 2'b01;
        i_base    = inv_cnt;
        a_base    = ack_cnt;
        repeat (4) tick();
        chk("rs_busy_settle", busy_o, 1);
        arst_i = 1'b1;
        tick();
        chk("rs_busy", busy_o, 0);
        chk("rs_mready", m_ready_o, 1);
        chk("rs_ack", inv_ack_o, 0);
        chk("rs_timeout", timeout_o, 0);
        arst_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("rs_inv_c%0d", c), invalidate_o, (c == 3));
            chk($sformatf("rs_ack_c%0d", c), inv_ack_o, (c == 6) ? 2'b01 : 2'b00);
        end
        inv_req_i = 2'b00;
        tick();
        chk("rs_ack_count", ack_cnt - a_base, 1);
        chk("rs_inv_count", inv_cnt - i_base, 2);

        // Clock enable low while the invalidate is due.
        inv_req_i = 2'b10;
        i_base    = inv_cnt;
        repeat (3) tick();
        chk("ck_inv_due", invalidate_o, 1);
        cke_i = 1'b0;
        #1;
        chk("ck_inv_masked", invalidate_o, 0);
        repeat (2) tick();
        chk("ck_inv_frozen", invalidate_o, 0);
        chk("ck_busy", busy_o, 1);
        cke_i = 1'b1;
        #1;
        chk("ck_inv_resume", invalidate_o, 1);
        tick();
        chk("ck_inv_off", invalidate_o, 0);
        repeat (2) tick();
        chk("ck_ack", inv_ack_o, 2'b10);
        inv_req_i = 2'b00;
        tick();
        chk("ck_inv_count", inv_cnt - i_base, 1);
        chk("ck_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
